clock_period_meter: RTL and testbench



---
 rtl/clock_period_meter.sv | 157 +++++++++++++++
 tb/tb_clock_period_meter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// Health monitor for a slow derived clock: measures period and high time in baseClock
// cycles, checks tolerance, tracks lock and flags a stalled clock.
module clock_period_meter #(
    parameter int                         COUNT_BIT_WIDTH = 27,
    parameter logic [COUNT_BIT_WIDTH-1:0] EXPECTED_PERIOD = 27'd100000000,
    parameter logic [COUNT_BIT_WIDTH-1:0] TOLERANCE       = 27'd1000,
    parameter int                         LOCK_COUNT      = 4,
    parameter logic [COUNT_BIT_WIDTH-1:0] TIMEOUT_CYCLES  = 27'd110000000
) (
    input  logic                       baseClock,
    input  logic                       reset,
    input  logic                       measClock,
    output logic [COUNT_BIT_WIDTH-1:0] period,
    output logic [COUNT_BIT_WIDTH-1:0] highTime,
    output logic                       periodValid,
    output logic                       inRange,
    output logic                       locked,
    output logic                       stalled,
    output logic [15:0]                edgeCount
);

    localparam int W  = COUNT_BIT_WIDTH;
    localparam int LW = $clog2(LOCK_COUNT + 1) + 1;
    localparam logic [W-1:0]  ALL_ONES = {W{1'b1}};
    localparam logic [W:0]    ONE_EXT  = {{W{1'b0}}, 1'b1};
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);
    localparam logic [LW-1:0] LOCK_ONE = {{(LW-1){1'b0}}, 1'b1};

    logic          s1_q, s2_q, s3_q;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  hcnt_q, hcnt_d;
    logic          armed_q, armed_d;
    logic [LW-1:0] lock_run_q, lock_run_d;
    logic [W-1:0]  period_q, period_d;
    logic [W-1:0]  high_q, high_d;
    logic          valid_q, valid_d;
    logic          in_range_q, in_range_d;
    logic          locked_q, locked_d;
    logic          stalled_q, stalled_d;
    logic [15:0]   edge_q, edge_d;

    logic          rise_s;
    logic [W:0]    cnt_inc_s;
    logic [W-1:0]  cnt_sat_s;
    logic [W:0]    hcnt_inc_s;
    logic [W-1:0]  hcnt_sat_s;
    logic [W:0]    abs_diff_s;
    logic          in_tol_s;
    logic          timeout_s;
    logic [LW-1:0] lock_run_inc_s;

    assign rise_s     = s2_q & ~s3_q;
    assign cnt_inc_s  = {1'b0, cnt_q} + ONE_EXT;
    assign cnt_sat_s  = cnt_inc_s[W] ? ALL_ONES : cnt_inc_s[W-1:0];
    assign hcnt_inc_s = {1'b0, hcnt_q} + ONE_EXT;
    assign hcnt_sat_s = hcnt_inc_s[W] ? ALL_ONES : hcnt_inc_s[W-1:0];

    // Distance from nominal, one bit wider so cnt+1 never wraps; overflow means out of range
    assign abs_diff_s = (cnt_inc_s >= {1'b0, EXPECTED_PERIOD}) ? (cnt_inc_s - {1'b0, EXPECTED_PERIOD})
                                                              : ({1'b0, EXPECTED_PERIOD} - cnt_inc_s);
    assign in_tol_s   = ~cnt_inc_s[W] & (abs_diff_s <= {1'b0, TOLERANCE});
    assign timeout_s  = armed_q & ~rise_s & (cnt_inc_s == {1'b0, TIMEOUT_CYCLES});
    assign lock_run_inc_s = (lock_run_q >= LOCK_MAX) ? LOCK_MAX : (lock_run_q + LOCK_ONE);

    // Next-state logic for counters, measurement results, lock and stall tracking
    always_comb begin
        cnt_d      = rise_s ? {W{1'b0}} : cnt_sat_s;
        edge_d     = rise_s ? (edge_q + 16'd1) : edge_q;
        hcnt_d     = hcnt_q;
        armed_d    = armed_q;
        lock_run_d = lock_run_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        in_range_d = in_range_q;
        locked_d   = locked_q;
        stalled_d  = stalled_q;

        if (rise_s) begin
            hcnt_d = {{(W-1){1'b0}}, 1'b1};
        end else if (s2_q) begin
            hcnt_d = hcnt_sat_s;
        end else begin
            hcnt_d = hcnt_q;
        end

        if (rise_s) begin
            if (armed_q && !stalled_q) begin
                period_d   = cnt_sat_s;
                high_d     = hcnt_q;
                valid_d    = 1'b1;
                in_range_d = in_tol_s;
                if (in_tol_s) begin
                    lock_run_d = lock_run_inc_s;
                    locked_d   = (lock_run_inc_s == LOCK_MAX);
                end else begin
                    lock_run_d = {LW{1'b0}};
                    locked_d   = 1'b0;
                end
            end else begin
                // First edge after reset or stall only re-arms; the partial period is unusable
                armed_d   = 1'b1;
                stalled_d = 1'b0;
            end
        end else if (timeout_s) begin
            stalled_d  = 1'b1;
            locked_d   = 1'b0;
            lock_run_d = {LW{1'b0}};
        end else begin
            stalled_d  = stalled_q;
        end
    end

    // State registers, including the three-flop edge synchronizer
    always_ff @(posedge baseClock) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            cnt_q      <= {W{1'b0}};
            hcnt_q     <= {W{1'b0}};
            armed_q    <= 1'b0;
            lock_run_q <= {LW{1'b0}};
            period_q   <= {W{1'b0}};
            high_q     <= {W{1'b0}};
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            locked_q   <= 1'b0;
            stalled_q  <= 1'b0;
            edge_q     <= 16'd0;
        end else begin
            s1_q       <= measClock;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            cnt_q      <= cnt_d;
            hcnt_q     <= hcnt_d;
            armed_q    <= armed_d;
            lock_run_q <= lock_run_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            in_range_q <= in_range_d;
            locked_q   <= locked_d;
            stalled_q  <= stalled_d;
            edge_q     <= edge_d;
        end
    end

    assign period      = period_q;
    assign highTime    = high_q;
    assign periodValid = valid_q;
    assign inRange     = in_range_q;
    assign locked      = locked_q;
    assign stalled     = stalled_q;
    assign edgeCount   = edge_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter with small parameters (nominal period 10, timeout 40).
module tb_clock_period_meter;

    localparam int W = 8;

    logic         baseClock = 1'b0;
    logic         reset     = 1'b1;
    logic         measClock = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] highTime;
    logic         periodValid;
    logic         inRange;
    logic         locked;
    logic         stalled;
    logic [15:0]  edgeCount;

    int           n_compared   = 0;
    int           n_mismatched = 0;
    int           nvalid       = 0;
    logic [W-1:0] v_period;
    logic [W-1:0] v_high;
    logic         v_in;
    logic         v_lock;

    clock_period_meter #(
        .COUNT_BIT_WIDTH(W),
        .EXPECTED_PERIOD(8'd10),
        .TOLERANCE      (8'd1),
        .LOCK_COUNT     (3),
        .TIMEOUT_CYCLES (8'd40)
    ) dut (
        .baseClock  (baseClock),
        .reset      (reset),
        .measClock  (measClock),
        .period     (period),
        .highTime   (highTime),
        .periodValid(periodValid),
        .inRange    (inRange),
        .locked     (locked),
        .stalled    (stalled),
        .edgeCount  (edgeCount)
    );

    always #5 baseClock = ~baseClock;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge baseClock);
        #1;
    endtask

    task automatic sample_valid();
        if (periodValid === 1'b1) begin
            nvalid++;
            v_period = period;
            v_high   = highTime;
            v_in     = inRange;
            v_lock   = locked;
        end
    endtask

    // One measClock period of h high then l low cycles, recording any valid pulse seen
    task automatic drive_period(input int h, input int l);
        nvalid = 0;
        for (int i = 0; i < h + l; i++) begin
            measClock = (i < h);
            tick();
            sample_valid();
        end
    endtask

    task automatic check_meas(input string tag, input int p, input int hi, input int inr, input int lk);
        check_value({tag, "_nvalid"}, 64'(nvalid), 64'd1);
        check_value({tag, "_period"}, 64'(v_period), 64'(p));
        check_value({tag, "_high"},   64'(v_high),   64'(hi));
        check_value({tag, "_inrange"}, 64'(v_in),    64'(inr));
        check_value({tag, "_locked"}, 64'(v_lock),   64'(lk));
    endtask

    task automatic check_all_zero(input string tag);
        check_value(tag, 64'({period, highTime, periodValid, inRange, locked, stalled, edgeCount}), 64'd0);
    endtask

    initial begin
        // Reset held with measClock toggling
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            measClock = ~measClock;
            tick();
            check_all_zero("reset_hold");
        end
        reset     = 1'b0;
        measClock = 1'b0;
        tick();
        check_all_zero("post_reset");

        // Nominal 5/5 periods: arm, then three valid measurements reaching lock
        drive_period(5, 5);
        check_value("arm_nvalid", 64'(nvalid), 64'd0);
        check_value("arm_edges", 64'(edgeCount), 64'd1);
        drive_period(5, 5);
        check_meas("nom1", 10, 5, 1, 0);
        drive_period(5, 5);
        check_meas("nom2", 10, 5, 1, 0);
        drive_period(5, 5);
        check_meas("nom3", 10, 5, 1, 1);
        check_value("nom_edges", 64'(edgeCount), 64'd4);

        // One long period breaks lock, three good periods restore it
        drive_period(6, 6);
        check_meas("pre_long", 10, 5, 1, 1);
        drive_period(5, 5);
        check_meas("long12", 12, 6, 0, 0);
        drive_period(5, 5);
        check_meas("relock1", 10, 5, 1, 0);
        drive_period(5, 5);
        check_meas("relock2", 10, 5, 1, 0);
        drive_period(5, 5);
        check_meas("relock3", 10, 5, 1, 1);

        // Tolerance edges: 9 and 11 in range, 8 out and clears the lock run
        drive_period(5, 4);
        check_meas("pre_tol", 10, 5, 1, 1);
        drive_period(6, 5);
        check_meas("p9", 9, 5, 1, 1);
        drive_period(4, 4);
        check_meas("p11", 11, 6, 1, 1);
        drive_period(5, 5);
        check_meas("p8", 8, 4, 0, 0);
        drive_period(5, 5);
        check_meas("run1", 10, 5, 1, 0);
        drive_period(5, 5);
        check_meas("run2", 10, 5, 1, 0);
        drive_period(5, 5);
        check_meas("run3", 10, 5, 1, 1);
        check_value("tol_edges", 64'(edgeCount), 64'd16);

        // Stall: measClock stops low after a rise; stall registers 40 cycles after detect
        nvalid = 0;
        for (int i = 0; i < 43; i++) begin
            measClock = (i < 5);
            tick();
            sample_valid();
            if (i == 41) begin
                check_value("pre_stall_stalled", 64'(stalled), 64'd0);
                check_value("pre_stall_locked", 64'(locked), 64'd1);
            end
            if (i == 42) begin
                check_value("stall_stalled", 64'(stalled), 64'd1);
                check_value("stall_locked", 64'(locked), 64'd0);
            end
        end
        check_meas("last_before_stall", 10, 5, 1, 1);
        check_value("stall_edges", 64'(edgeCount), 64'd17);

        // Restart: first rise re-arms only, second gives a fresh measurement
        drive_period(5, 5);
        check_value("restart_nvalid", 64'(nvalid), 64'd0);
        check_value("restart_stalled", 64'(stalled), 64'd0);
        check_value("restart_edges", 64'(edgeCount), 64'd18);
        drive_period(5, 5);
        check_meas("restart_meas", 10, 5, 1, 0);

        // Reset four cycles into a period discards it
        measClock = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        check_all_zero("mid_reset");
        reset     = 1'b0;
        measClock = 1'b0;
        tick();
        check_all_zero("post_reset2");
        for (int i = 0; i < 3; i++) tick();
        drive_period(5, 5);
        check_value("rearm_nvalid", 64'(nvalid), 64'd0);
        check_value("rearm_edges", 64'(edgeCount), 64'd1);
        drive_period(5, 5);
        check_meas("after_reset", 10, 5, 1, 0);
        check_value("after_reset_edges", 64'(edgeCount), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
